// File: rtl/fsqrt_root_iter.sv
// fsqrt_root_iter
// Digit-recurrence square-root core for the binary32 FSQRT datapath.
// Takes a normalised 24-bit fraction from the even-bit normaliser. Produces
// the truncated root floor(sqrt(frac * 2^24)) one bit per cycle over 24 cycles.
// Also produces a sticky bit, set when the final remainder is non-zero.
//
// Ports
//   clk     in   1   clock, rising edge
//   clrn    in   1   asynchronous active-low reset
//   start   in   1   request, accepted when busy=0 (IDLE or DONE)
//   frac    in   24  normalised fraction, sampled on accept
//   sa_in   in   5   even shift amount, sampled on accept
//   busy    out  1   iteration in progress
//   done    out  1   one-cycle result-valid pulse
//   root    out  24  truncated root, held until the next result is written
//   sticky  out  1   remainder non-zero, held with root
//   sa_out  out  5   shift amount captured at accept
//
// state | meaning
// IDLE  | waiting for start, busy=0
// CALC  | 24 restoring iterations, busy=1
// DONE  | result valid, done=1 for one cycle, start accepted here too

module fsqrt_root_iter (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [23:0] frac,
  input  logic [4:0]  sa_in,
  output logic        busy,
  output logic        done,
  output logic [23:0] root,
  output logic        sticky,
  output logic [4:0]  sa_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [47:0] rad;
  logic [25:0] rem;
  logic [23:0] q;
  logic [4:0]  cnt;

  logic        accept;
  logic        last_iter;
  logic [25:0] r_shift;
  logic [25:0] trial;
  logic        take;
  logic [25:0] rem_nxt;
  logic [23:0] q_nxt;

  // A request is honoured in every state except CALC.
  assign accept    = start && (state != CALC);
  assign last_iter = (cnt == 5'd23);

  // Restoring recurrence step: bring down the next radicand digit pair and
  // try to subtract 4q+1. The remainder is bounded by 2q+1, so the top two
  // bits of rem are always zero before the shift and 26 bits never overflow.
  assign r_shift = {rem[23:0], rad[47:46]};
  assign trial   = {q, 2'b01};
  assign take    = (r_shift >= trial);
  assign rem_nxt = take ? (r_shift - trial) : r_shift;
  assign q_nxt   = {q[22:0], take};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = CALC;
      end
      CALC: begin
        if (last_iter) next_state = DONE;
      end
      DONE: begin
        if (accept) next_state = CALC;
        else        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // busy and done decode straight from the state flops, so no input reaches
  // an output combinationally.
  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rad    <= '0;
      rem    <= '0;
      q      <= '0;
      cnt    <= '0;
      root   <= '0;
      sticky <= 1'b0;
      sa_out <= '0;
    end else if (accept) begin
      // root/sticky stay untouched so the previous result remains readable
      // while the next operation runs.
      rad    <= {frac, 24'b0};
      rem    <= '0;
      q      <= '0;
      cnt    <= '0;
      sa_out <= sa_in;
    end else if (state == CALC) begin
      rad <= {rad[45:0], 2'b00};
      rem <= rem_nxt;
      q   <= q_nxt;
      cnt <= cnt + 5'd1;
      if (last_iter) begin
        root   <= q_nxt;
        sticky <= |rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fsqrt_root_iter.sv
module tb_fsqrt_root_iter;

  logic        clk;
  logic        clrn;
  logic        start;
  logic [23:0] frac;
  logic [4:0]  sa_in;
  logic        busy;
  logic        done;
  logic [23:0] root;
  logic        sticky;
  logic [4:0]  sa_out;

  int checks;
  int errors;

  fsqrt_root_iter dut (
    .clk    (clk),
    .clrn   (clrn),
    .start  (start),
    .frac   (frac),
    .sa_in  (sa_in),
    .busy   (busy),
    .done   (done),
    .root   (root),
    .sticky (sticky),
    .sa_out (sa_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before anything is sampled or driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns with start already low.
  task automatic issue(input logic [23:0] f, input logic [4:0] s);
    start = 1'b1;
    frac  = f;
    sa_in = s;
    tick();
    start = 1'b0;
  endtask

  // Count edges until done is seen; -1 when the budget runs out.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 60) begin
      tick();
      n++;
      if (done) return;
    end
    n = -1;
  endtask

  task automatic run_op(input string tag, input logic [23:0] f, input logic [4:0] s,
                        input logic [23:0] exp_root, input logic exp_sticky);
    int n;
    issue(f, s);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({tag, "_lat"}, 32'(n), 32'd24);
    chk({tag, "_root"}, 32'(root), 32'(exp_root));
    chk({tag, "_sticky"}, 32'(sticky), 32'(exp_sticky));
    chk({tag, "_sa"}, 32'(sa_out), 32'(s));
    chk({tag, "_nbusy"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_dlow"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int dcount;
    checks = 0;
    errors = 0;
    clrn   = 1'b0;
    start  = 1'b0;
    frac   = '0;
    sa_in  = '0;

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_root", 32'(root), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);
    chk("rst_sa", 32'(sa_out), 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    tick();

    run_op("exact",   24'h400000, 5'd4,  24'h800000, 1'b0);
    run_op("inexact", 24'h800000, 5'd6,  24'hB504F3, 1'b1);
    run_op("square",  24'h900000, 5'd2,  24'hC00000, 1'b0);
    run_op("max",     24'hFFFFFF, 5'd10, 24'hFFFFFF, 1'b1);
    run_op("zero",    24'h000000, 5'd0,  24'h000000, 1'b0);

    // Requests during CALC must be ignored: one done, first operand's result.
    issue(24'h800000, 5'd8);
    for (int i = 0; i < 20; i++) begin
      start = 1'b1;
      frac  = 24'h900000;
      sa_in = 5'd30;
      tick();
      chk("ign_sa_hold", 32'(sa_out), 32'd8);
    end
    start  = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        dcount++;
        chk("ign_root", 32'(root), 32'hB504F3);
        chk("ign_sticky", 32'(sticky), 32'd1);
        chk("ign_sa", 32'(sa_out), 32'd8);
      end
    end
    chk("ign_ndone", 32'(dcount), 32'd1);

    // Back-to-back: start held in the DONE cycle.
    issue(24'h800000, 5'd12);
    wait_done(n);
    chk("b2b_lat1", 32'(n), 32'd24);
    chk("b2b_root1", 32'(root), 32'hB504F3);
    issue(24'h400000, 5'd14);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_gone", 32'(done), 32'd0);
    chk("b2b_root_held", 32'(root), 32'hB504F3);
    chk("b2b_sticky_held", 32'(sticky), 32'd1);
    chk("b2b_sa_new", 32'(sa_out), 32'd14);
    wait_done(n);
    chk("b2b_gap", 32'(n + 1), 32'd25);
    chk("b2b_root2", 32'(root), 32'h800000);
    chk("b2b_sticky2", 32'(sticky), 32'd0);
    tick();

    // Reset while iterating: outputs clear at once, nothing follows release.
    issue(24'hFFFFFF, 5'd16);
    for (int i = 0; i < 10; i++) tick();
    #2;
    clrn = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_root", 32'(root), 32'd0);
    chk("mid_sticky", 32'(sticky), 32'd0);
    chk("mid_sa", 32'(sa_out), 32'd0);
    @(negedge clk);
    clrn   = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) dcount++;
    end
    chk("mid_quiet", 32'(dcount), 32'd0);
    run_op("post", 24'h900000, 5'd18, 24'hC00000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
